// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM kernel family: state encodings and counter sizing.
package hlsm_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    S_WAIT  = 3'd0,
    S_FINAL = 3'd1,
    S_C1    = 3'd2,
    S_C2    = 3'd3,
    S_C3    = 3'd4,
    S_C4    = 3'd5
  } state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(int unsigned n);
    int unsigned w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/hlsm_cond_loop_if.sv
// Start/Done control handshake plus operand and result bus of an HLSM kernel.
interface hlsm_cond_loop_if #(
  parameter int unsigned DATAWIDTH = 32
) ();

  logic                        start;
  logic                        done;
  logic                        busy;
  logic                        t;
  logic signed [DATAWIDTH-1:0] a;
  logic signed [DATAWIDTH-1:0] b;
  logic signed [DATAWIDTH-1:0] c;
  logic signed [DATAWIDTH-1:0] one;
  logic signed [DATAWIDTH-1:0] z;
  logic signed [DATAWIDTH-1:0] x;

  modport master (
    output start, t, a, b, c, one,
    input  done, busy, z, x
  );

  modport slave (
    input  start, t, a, b, c, one,
    output done, busy, z, x
  );

endinterface

// File: rtl/hlsm_iter_counter.sv
// Iteration counter for the looped HLSM kernels; flags the final iteration.
module hlsm_iter_counter
  import hlsm_pkg::*;
#(
  parameter int unsigned ITERS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  output logic last
);

  localparam int unsigned CntWidth = clog2(ITERS);
  localparam logic [CntWidth-1:0] LastVal = CntWidth'(ITERS - 1);

  logic [CntWidth-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LastVal);

endmodule

// File: rtl/hlsm_cond_loop.sv
// Predicated four-cycle HLSM kernel repeated ITERS times per Start, accumulating f - d into x.
module hlsm_cond_loop
  import hlsm_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ITERS     = 4
) (
  input logic             clk,
  input logic             rst,
  hlsm_cond_loop_if.slave bus
);

  state_e                      state;
  logic signed [DATAWIDTH-1:0] d, e, f;
  logic signed [DATAWIDTH-1:0] a_r, b_r, c_r, one_r;
  logic signed [DATAWIDTH-1:0] z_q, x_q;
  logic                        g, t_r;
  logic                        done_q, busy_q;
  logic                        last;

  hlsm_iter_counter #(
    .ITERS(ITERS)
  ) u_iter_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(state == S_WAIT && bus.start),
    .step (state == S_C4 && !last),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_WAIT;
      d      <= '0;
      e      <= '0;
      f      <= '0;
      g      <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= '0;
      one_r  <= '0;
      t_r    <= 1'b0;
      z_q    <= '0;
      x_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            c_r    <= bus.c;
            one_r  <= bus.one;
            t_r    <= bus.t;
            x_q    <= '0;
            z_q    <= '0;
            busy_q <= 1'b1;
            state  <= S_C1;
          end
        end
        S_C1: begin
          d <= a_r + b_r;
          if (!t_r) begin
            e <= a_r + c_r;
            f <= a_r * c_r;
          end
          state <= S_C2;
        end
        S_C2: begin
          if (t_r) d <= a_r - one_r;
          state <= S_C3;
        end
        S_C3: begin
          if (t_r) f <= a_r + c_r;
          else     g <= (d > e);
          state <= S_C4;
        end
        S_C4: begin
          x_q <= x_q + (f - d);
          if (!t_r) z_q <= g ? d : e;
          if (last) begin
            state <= S_FINAL;
          end else begin
            a_r   <= a_r + one_r;
            state <= S_C1;
          end
        end
        S_FINAL: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.z    = z_q;
  assign bus.x    = x_q;

endmodule
